// File: rtl/gat_pkg.sv
// Shared types and default sizing for the GAT layer datapath and its sequencer.
package gat_pkg;

   localparam int GAT_NEW_FEATURE_WIDTH  = 32;
   localparam int GAT_NUM_SUBGRAPHS      = 2708;
   localparam int GAT_NUM_FEATURE_OUT    = 16;
   localparam int GAT_NEW_FEATURE_DEPTH  = GAT_NUM_SUBGRAPHS * GAT_NUM_FEATURE_OUT;
   localparam int GAT_NEW_FEATURE_ADDR_W = $clog2(GAT_NEW_FEATURE_DEPTH);
   localparam int GAT_TIMEOUT_W          = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_LOAD,
      ST_LAUNCH,
      ST_RUN,
      ST_DRAIN,
      ST_DONE,
      ST_ERROR
   } gat_seq_state_t;

endpackage

// File: rtl/gat_feat_skid_fifo.sv
// Two-entry registered FIFO absorbing the feature BRAM read latency under backpressure.
module gat_feat_skid_fifo #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         head_valid,
   output logic [W-1:0] head_data,
   output logic [1:0]   count
);

   logic [1:0][W-1:0] mem_q, mem_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              pop_ok, push_ok;

   always_comb begin
      pop_ok   = pop && (cnt_q != 2'd0);
      push_ok  = push && ((cnt_q != 2'd2) || pop_ok);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         cnt_d    = 2'd0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop_ok) rd_ptr_d = ~rd_ptr_q;
         cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign head_valid = (cnt_q != 2'd0);
   assign head_data  = mem_q[rd_ptr_q];
   assign count      = cnt_q;

endmodule

// File: rtl/gat_layer_sequencer.sv
// Runs one GAT layer: waits for loads, launches the core, then drains new features as a stream.
module gat_layer_sequencer
   import gat_pkg::*;
#(
   parameter int NEW_FEATURE_WIDTH  = GAT_NEW_FEATURE_WIDTH,
   parameter int NUM_SUBGRAPHS      = GAT_NUM_SUBGRAPHS,
   parameter int NUM_FEATURE_OUT    = GAT_NUM_FEATURE_OUT,
   parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
   parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
   parameter int TIMEOUT_W          = GAT_TIMEOUT_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          abort,
   input  logic                          layer_sel,
   input  logic [TIMEOUT_W-1:0]          timeout_limit,
   input  logic                          h_data_load_done,
   input  logic                          h_node_info_load_done,
   input  logic                          wgt_load_done,
   output logic                          gat_layer,
   output logic                          gat_start,
   input  logic                          gat_ready,
   output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb,
   input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [NEW_FEATURE_WIDTH-1:0]  m_data,
   output logic                          m_last,
   output logic                          busy,
   output logic                          done,
   output logic                          err_timeout,
   output logic [TIMEOUT_W-1:0]          run_cycles
);

   localparam int               IDX_W    = $clog2(NEW_FEATURE_DEPTH + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEW_FEATURE_DEPTH - 1);
   localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(NEW_FEATURE_DEPTH);

   gat_seq_state_t         state_q, state_d;
   logic                   layer_q, layer_d;
   logic [TIMEOUT_W-1:0]   run_cycles_q, run_cycles_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   ready_prev_q;
   logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
   logic                   rd_pend_q, rd_pend_d;
   logic                   rd_pend_last_q, rd_pend_last_d;

   logic                         accept, rise, issue, pop, abort_act;
   logic [2:0]                   occ;
   logic [1:0]                   fifo_count;
   logic                         fifo_vld;
   logic [NEW_FEATURE_WIDTH:0]   fifo_head;

   gat_feat_skid_fifo #(.W(NEW_FEATURE_WIDTH + 1)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (abort_act),
      .push       (rd_pend_q),
      .push_data  ({rd_pend_last_q, feat_bram_dout}),
      .pop        (pop),
      .head_valid (fifo_vld),
      .head_data  (fifo_head),
      .count      (fifo_count)
   );

   // Stream and read-issue handshakes are combinational so the drain sustains one word per cycle.
   always_comb begin
      abort_act = abort && (state_q != ST_IDLE);
      accept    = start && !abort && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
      rise      = gat_ready && !ready_prev_q;
      m_valid   = fifo_vld && (state_q == ST_DRAIN) && !abort;
      m_data    = fifo_head[NEW_FEATURE_WIDTH-1:0];
      m_last    = m_valid && fifo_head[NEW_FEATURE_WIDTH];
      pop       = m_valid && m_ready;
      occ       = 3'(fifo_count) + 3'(rd_pend_q) - 3'(pop);
      issue     = (state_q == ST_DRAIN) && !abort && (rd_idx_q < END_IDX) && (occ < 3'd2);
      feat_bram_addrb = issue ? NEW_FEATURE_ADDR_W'(rd_idx_q) : '0;
   end

   always_comb begin
      state_d        = state_q;
      layer_d        = layer_q;
      run_cycles_d   = run_cycles_q;
      done_d         = done_q;
      err_d          = err_q;
      rd_idx_d       = issue ? rd_idx_q + IDX_W'(1) : rd_idx_q;
      rd_pend_d      = issue;
      rd_pend_last_d = issue && (rd_idx_q == LAST_IDX);
      if (abort_act) begin
         state_d = ST_IDLE;
      end else if (accept) begin
         state_d      = ST_WAIT_LOAD;
         layer_d      = layer_sel;
         run_cycles_d = '0;
         done_d       = 1'b0;
         err_d        = 1'b0;
      end else begin
         case (state_q)
            ST_WAIT_LOAD:
               if (h_data_load_done && h_node_info_load_done && wgt_load_done) state_d = ST_LAUNCH;
            ST_LAUNCH:
               state_d = ST_RUN;
            ST_RUN: begin
               if (run_cycles_q != '1) run_cycles_d = run_cycles_q + TIMEOUT_W'(1);
               // A completion edge beats a timeout landing on the same cycle.
               if (rise) begin
                  state_d  = ST_DRAIN;
                  rd_idx_d = '0;
               end else if ((timeout_limit != '0) &&
                            (run_cycles_q == timeout_limit - TIMEOUT_W'(1))) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end
            end
            ST_DRAIN:
               if (pop && fifo_head[NEW_FEATURE_WIDTH]) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         layer_q        <= 1'b0;
         run_cycles_q   <= '0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
         ready_prev_q   <= 1'b0;
         rd_idx_q       <= '0;
         rd_pend_q      <= 1'b0;
         rd_pend_last_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         layer_q        <= layer_d;
         run_cycles_q   <= run_cycles_d;
         done_q         <= done_d;
         err_q          <= err_d;
         ready_prev_q   <= gat_ready;
         rd_idx_q       <= rd_idx_d;
         rd_pend_q      <= rd_pend_d;
         rd_pend_last_q <= rd_pend_last_d;
      end
   end

   assign gat_layer   = layer_q;
   assign gat_start   = (state_q == ST_LAUNCH);
   assign busy        = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
   assign done        = done_q;
   assign err_timeout = err_q;
   assign run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_gat_layer_sequencer.sv
// Scoreboard bench for gat_layer_sequencer with an 8-word feature BRAM holding i+100.
module tb_gat_layer_sequencer;

   localparam int W  = 32;
   localparam int AW = 3;
   localparam int TW = 32;

   logic          clk = 1'b0;
   logic          rst, start, abort, layer_sel;
   logic [TW-1:0] timeout_limit;
   logic          h_data_load_done, h_node_info_load_done, wgt_load_done;
   logic          gat_layer, gat_start, gat_ready;
   logic [AW-1:0] feat_bram_addrb;
   logic [W-1:0]  feat_bram_dout;
   logic          m_valid, m_ready, m_last;
   logic [W-1:0]  m_data;
   logic          busy, done, err_timeout;
   logic [TW-1:0] run_cycles;

   int            checks = 0;
   int            errors = 0;
   int            hs_count = 0;
   logic [W:0]    exp_q[$];
   logic          bp_mode = 1'b0;
   logic [3:0]    bp_pat = 4'b1001;
   int            bp_ph = 0;
   logic          stall_q = 1'b0;
   logic [W-1:0]  stall_data = '0;

   gat_layer_sequencer #(
      .NEW_FEATURE_WIDTH (W),
      .NUM_SUBGRAPHS     (2),
      .NUM_FEATURE_OUT   (4),
      .TIMEOUT_W         (TW)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .start                 (start),
      .abort                 (abort),
      .layer_sel             (layer_sel),
      .timeout_limit         (timeout_limit),
      .h_data_load_done      (h_data_load_done),
      .h_node_info_load_done (h_node_info_load_done),
      .wgt_load_done         (wgt_load_done),
      .gat_layer             (gat_layer),
      .gat_start             (gat_start),
      .gat_ready             (gat_ready),
      .feat_bram_addrb       (feat_bram_addrb),
      .feat_bram_dout        (feat_bram_dout),
      .m_valid               (m_valid),
      .m_ready               (m_ready),
      .m_data                (m_data),
      .m_last                (m_last),
      .busy                  (busy),
      .done                  (done),
      .err_timeout           (err_timeout),
      .run_cycles            (run_cycles)
   );

   always #5 clk = ~clk;

   // BRAM model: one-cycle read latency, mem[i] = i + 100
   always @(posedge clk) feat_bram_dout <= 32'(feat_bram_addrb) + 32'd100;

   always @(posedge clk) begin
      #1;
      m_ready = bp_mode ? bp_pat[bp_ph] : 1'b1;
      bp_ph   = (bp_ph + 1) % 4;
   end

   // Monitor: pops the scoreboard on every handshake and checks the holding rule under stall.
   always @(negedge clk) begin
      logic [W:0] e;
      if (!rst) begin
         if (stall_q) begin
            checks++;
            if (!(m_valid && m_data == stall_data)) begin
               errors++;
               $display("FAIL hold: valid=%0b data=%0d required valid=1 data=%0d", m_valid, m_data, stall_data);
            end
         end
         if (m_valid && m_ready) begin
            checks++;
            hs_count++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_word: got data=%0d last=%0b with nothing expected", m_data, m_last);
            end else begin
               e = exp_q.pop_front();
               if ({m_last, m_data} !== e) begin
                  errors++;
                  $display("FAIL word: got data=%0d last=%0b required data=%0d last=%0b", m_data, m_last, e[W-1:0], e[W]);
               end
            end
         end
         stall_q    = m_valid && !m_ready;
         stall_data = m_data;
      end else begin
         stall_q = 1'b0;
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic push_words();
      for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 32'(100 + i)});
   endtask

   task automatic wait_done(input string name, input int bound);
      for (int i = 0; i < bound && !done; i++) step(1);
      chk(name, done, 1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   initial begin
      int cnt;
      int hs0;
      rst = 1'b1; start = 1'b0; abort = 1'b0; layer_sel = 1'b0; timeout_limit = '0;
      h_data_load_done = 1'b0; h_node_info_load_done = 1'b0; wgt_load_done = 1'b0;
      gat_ready = 1'b0;
      step(3);
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_start", gat_start, 0);
      chk("rst_run_cycles", run_cycles, 0);
      chk("rst_addr", feat_bram_addrb, 0);

      // nominal run
      layer_sel = 1'b1;
      pulse_start();
      chk("nom_busy", busy, 1);
      step(4);
      h_data_load_done = 1'b1; h_node_info_load_done = 1'b1; wgt_load_done = 1'b1;
      step(1);
      chk("nom_launch", gat_start, 1);
      step(1);
      chk("nom_single_pulse", gat_start, 0);
      chk("nom_layer", gat_layer, 1);
      push_words();
      step(19);
      gat_ready = 1'b1;
      step(1);
      chk("nom_run_cycles", run_cycles, 20);
      for (int i = 0; i < 10 && !m_valid; i++) step(1);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (m_valid) cnt++;
         step(1);
      end
      chk("nom_consecutive", cnt, 8);
      chk("nom_done", done, 1);
      chk("nom_busy_after", busy, 0);
      chk("nom_drained", exp_q.size(), 0);
      gat_ready = 1'b0;

      // late loads, then drain under backpressure
      wgt_load_done = 1'b0;
      pulse_start();
      chk("late_done_cleared", done, 0);
      cnt = 0;
      for (int i = 0; i < 49; i++) begin
         if (gat_start) cnt++;
         step(1);
      end
      chk("late_no_early_start", cnt, 0);
      wgt_load_done = 1'b1;
      step(1);
      chk("late_start_after_and", gat_start, 1);
      bp_mode = 1'b1;
      push_words();
      step(1);
      gat_ready = 1'b1;
      step(1);
      wait_done("bp_done", 200);
      chk("bp_drained", exp_q.size(), 0);
      bp_mode = 1'b0;
      gat_ready = 1'b0;
      step(1);

      // timeout
      timeout_limit = 32'd10;
      pulse_start();
      step(2);
      step(9);
      chk("to_not_early", busy, 1);
      step(1);
      chk("to_err", err_timeout, 1);
      chk("to_busy", busy, 0);
      chk("to_run_cycles", run_cycles, 10);
      chk("to_no_stream", m_valid, 0);

      // ready already high on RUN entry is not a completion
      timeout_limit = '0;
      gat_ready = 1'b1;
      pulse_start();
      chk("to_err_cleared", err_timeout, 0);
      step(2);
      step(15);
      chk("held_no_drain_busy", busy, 1);
      chk("held_no_drain_valid", m_valid, 0);
      push_words();
      gat_ready = 1'b0;
      step(1);
      gat_ready = 1'b1;
      step(1);
      chk("held_run_cycles", run_cycles, 17);
      wait_done("held_done", 100);
      gat_ready = 1'b0;

      // edge on the timeout cycle wins
      timeout_limit = 32'd5;
      pulse_start();
      step(2);
      step(4);
      chk("tie_pre_busy", busy, 1);
      gat_ready = 1'b1;
      push_words();
      step(1);
      chk("tie_no_err", err_timeout, 0);
      chk("tie_draining", busy, 1);
      wait_done("tie_done", 100);
      gat_ready = 1'b0;
      timeout_limit = '0;

      // abort mid-drain, then replay
      push_words();
      pulse_start();
      step(2);
      gat_ready = 1'b1;
      step(1);
      gat_ready = 1'b0;
      hs0 = hs_count;
      for (int i = 0; i < 20 && (hs_count - hs0) < 3; i++) step(1);
      chk("abort_after_three", hs_count - hs0, 3);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      chk("abort_valid", m_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done_kept", done, 0);
      exp_q.delete();
      push_words();
      pulse_start();
      step(2);
      gat_ready = 1'b1;
      step(1);
      gat_ready = 1'b0;
      wait_done("replay_done", 100);
      chk("replay_drained", exp_q.size(), 0);
      start = 1'b1; abort = 1'b1;
      step(1);
      start = 1'b0; abort = 1'b0;
      chk("abort_beats_start_busy", busy, 0);
      chk("abort_beats_start_done", done, 1);

      // reset during RUN with gat_ready held
      pulse_start();
      step(2);
      step(3);
      chk("rstrun_busy", busy, 1);
      rst = 1'b1;
      gat_ready = 1'b1;
      step(1);
      rst = 1'b0;
      chk("rstrun_busy0", busy, 0);
      chk("rstrun_done0", done, 0);
      chk("rstrun_layer0", gat_layer, 0);
      chk("rstrun_cycles0", run_cycles, 0);
      chk("rstrun_valid0", m_valid, 0);
      step(5);
      chk("rstrun_no_retrigger", busy, 0);
      chk("rstrun_no_stream", m_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
